// File: rtl/enc_step_pkg.sv
// Shared types and quadrature Gray-sequence helpers for the encoder-to-step generator.
package enc_step_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW} step_st_e;

    // Encodings line up with (index(cur) - index(prev)) mod 4 along the CW sequence.
    typedef enum logic [1:0] {Q_NONE, Q_FWD, Q_ILL, Q_REV} quad_e;

    // {A,B} in CW order
    localparam logic [3:0][1:0] GRAY_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (ab == GRAY_SEQ[i]) idx = 2'(i);
        return idx;
    endfunction

    function automatic quad_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
        return quad_e'(gray_idx(cur) - gray_idx(prev));
    endfunction

endpackage

// File: rtl/enc_step_gen_if.sv
// Encoder inputs, enable and step-driver / status outputs of enc_step_gen.
interface enc_step_gen_if #(
    parameter int PEND_W = 8
);
    logic              ENC_A;
    logic              ENC_B;
    logic              EN;
    logic              step;
    logic              dir;
    logic [15:0]       pos;
    logic [PEND_W-1:0] pend;
    logic              ovf;
    logic              err;

    modport master (output ENC_A, ENC_B, EN, input step, dir, pos, pend, ovf, err);
    modport slave  (input ENC_A, ENC_B, EN, output step, dir, pos, pend, ovf, err);
endinterface

// File: rtl/enc_glitch_filter.sv
// 2-flop synchroniser plus a filter that follows its input only after FILT_LEN
// consecutive cycles of disagreement.
module enc_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    sync_q, sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], din};
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) filt_d = sync_q[1];
            else                            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = filt_q;
endmodule

// File: rtl/enc_step_gen.sv
// Quadrature encoder follower: filters A/B, tracks position and a saturating
// pending-step count, and replays pending steps as STEP/DIR pulses.
module enc_step_gen
    import enc_step_pkg::*;
#(
    parameter int FILT_LEN  = 4,
    parameter int STEP_HI   = 50,
    parameter int STEP_LO   = 50,
    parameter int DIR_SETUP = 20,
    parameter int PEND_W    = 8
) (
    input logic           CLK,
    input logic           RSTN,
    enc_step_gen_if.slave bus
);
    localparam int TMAX0 = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
    localparam int TMAX  = (TMAX0 > DIR_SETUP) ? TMAX0 : DIR_SETUP;
    localparam int CNT_W = $clog2(TMAX + 1);
    localparam logic signed [PEND_W+1:0] PMAX = (PEND_W+2)'(2**(PEND_W-1) - 1);
    localparam logic signed [PEND_W+1:0] PONE = (PEND_W+2)'(1);

    logic [1:0] enc_raw, filt;
    assign enc_raw = {bus.ENC_A, bus.ENC_B};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .clk (CLK),
            .rstn(RSTN),
            .din (enc_raw[c]),
            .dout(filt[c])
        );
    end

    logic [1:0]        ab_prev_q, ab_prev_d;
    logic              ref_vld_q, ref_vld_d;
    logic              inc_q, inc_d, dec_q, dec_d;
    logic              err_q, err_d, ovf_q, ovf_d;
    logic [15:0]       pos_q, pos_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    step_st_e          state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_q, step_d, dir_q, dir_d;

    logic                     issue, pend_nz, pend_pos;
    logic signed [PEND_W+1:0] pend_x, d_cnt, d_stp, pend_sum;

    // Decode stage: the first filtered change after reset only seeds the reference.
    always_comb begin
        ab_prev_d = filt;
        ref_vld_d = ref_vld_q | (filt != ab_prev_q);
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        err_d     = err_q;
        if (ref_vld_q) begin
            case (quad_step(ab_prev_q, filt))
                Q_FWD:   inc_d = 1'b1;
                Q_REV:   dec_d = 1'b1;
                Q_ILL:   err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        pend_nz  = (pend_q != '0);
        pend_pos = pend_nz && !pend_q[PEND_W-1];
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        dir_d    = dir_q;
        issue    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.EN && pend_nz) begin
                    cnt_d = '0;
                    if (pend_pos != dir_q) begin
                        dir_d   = pend_pos;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_HIGH;
                        step_d  = 1'b1;
                        issue   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (!bus.EN) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(DIR_SETUP - 1)) begin
                    // Counts may have cancelled the request during setup; never step against pend.
                    cnt_d = '0;
                    if (pend_nz && pend_pos == dir_q) begin
                        state_d = ST_HIGH;
                        step_d  = 1'b1;
                        issue   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_q == CNT_W'(STEP_HI - 1)) begin
                    state_d = ST_LOW;
                    step_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q == CNT_W'(STEP_LO - 1)) state_d = ST_IDLE;
                else                              cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Count and step consumption net together; only a count can push past the rails.
    always_comb begin
        pos_d = pos_q;
        if (inc_q)      pos_d = pos_q + 16'd1;
        else if (dec_q) pos_d = pos_q - 16'd1;

        pend_x   = {{2{pend_q[PEND_W-1]}}, pend_q};
        d_cnt    = inc_q ? PONE : (dec_q ? -PONE : '0);
        d_stp    = issue ? (pend_pos ? PONE : -PONE) : '0;
        pend_sum = pend_x + d_cnt - d_stp;
        ovf_d    = ovf_q;
        if (pend_sum > PMAX) begin
            pend_d = PMAX[PEND_W-1:0];
            ovf_d  = 1'b1;
        end else if (pend_sum < -PMAX) begin
            pend_d = (-PMAX);
            ovf_d  = 1'b1;
        end else begin
            pend_d = pend_sum[PEND_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ab_prev_q <= '0;
            ref_vld_q <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            pos_q     <= '0;
            pend_q    <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            ab_prev_q <= ab_prev_d;
            ref_vld_q <= ref_vld_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            pos_q     <= pos_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
        end
    end

    assign bus.step = step_q;
    assign bus.dir  = dir_q;
    assign bus.pos  = pos_q;
    assign bus.pend = pend_q;
    assign bus.ovf  = ovf_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_enc_step_gen.sv
// Directed bench for enc_step_gen with FILT_LEN=4, STEP_HI=3, STEP_LO=3, DIR_SETUP=2, PEND_W=4.
module tb_enc_step_gen;
    localparam int PEND_W = 4;

    logic CLK = 1'b0;
    logic RSTN;
    always #5 CLK = ~CLK;

    enc_step_gen_if #(.PEND_W(PEND_W)) bus ();

    enc_step_gen #(
        .FILT_LEN(4), .STEP_HI(3), .STEP_LO(3), .DIR_SETUP(2), .PEND_W(PEND_W)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int eidx   = 0;
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Pulse monitor: counts rising edges and pulses whose high time is not 3 cycles.
    int   n_pulse = 0;
    int   n_badw  = 0;
    int   hi_run  = 0;
    logic step_p  = 1'b0;
    always @(negedge CLK) begin
        if (bus.step === 1'b1) begin
            if (!step_p) n_pulse <= n_pulse + 1;
            hi_run <= hi_run + 1;
        end else begin
            if (step_p && hi_run != 3) n_badw <= n_badw + 1;
            hi_run <= 0;
        end
        step_p <= (bus.step === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic enc_move(input int d);
        eidx = (eidx + d) & 3;
        bus.ENC_A = seq[eidx][1];
        bus.ENC_B = seq[eidx][0];
    endtask

    task automatic wait_rise(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (bus.step === 1'b1) begin k = i; break; end
        end
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        tick(3);
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        RSTN = 1'b0; bus.EN = 1'b0; bus.ENC_A = 1'b0; bus.ENC_B = 1'b0;
        tick(3);
        n_chk++; if (bus.step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b want 0", bus.step); end
        n_chk++; if (bus.dir  !== 1'b0) begin n_fail++; $display("FAIL rst_dir: got %b want 0", bus.dir); end
        n_chk++; if (bus.pos  !== 16'd0) begin n_fail++; $display("FAIL rst_pos: got %0d want 0", bus.pos); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL rst_pend: got %0d want 0", bus.pend); end
        n_chk++; if (bus.ovf  !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
        n_chk++; if (bus.err  !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
        RSTN = 1'b1;
        tick(2);
        // first filtered change after reset is only a reference
        enc_move(1);
        tick(20);
        n_chk++; if (bus.pos !== 16'd0) begin n_fail++; $display("FAIL prime_pos: got %0d want 0", bus.pos); end
        n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL prime_err: got %b want 0", bus.err); end
    endtask

    task automatic test_cw_steps();
        int k, p0, b0;
        p0 = n_pulse; b0 = n_badw;
        bus.EN = 1'b1;
        enc_move(1);
        wait_rise(k);
        n_chk++; if (k != 11) begin n_fail++; $display("FAIL cw_lat_dirchg: got %0d want 11", k); end
        n_chk++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL cw_dir: got %b want 1", bus.dir); end
        tick(20 - k);
        enc_move(1);
        wait_rise(k);
        n_chk++; if (k != 9) begin n_fail++; $display("FAIL cw_lat_same: got %0d want 9", k); end
        tick(20 - k);
        enc_move(1); tick(20);
        enc_move(1); tick(20);
        n_chk++; if (n_pulse - p0 != 4) begin n_fail++; $display("FAIL cw_pulses: got %0d want 4", n_pulse - p0); end
        n_chk++; if (n_badw - b0 != 0) begin n_fail++; $display("FAIL cw_width: got %0d bad want 0", n_badw - b0); end
        n_chk++; if (bus.pos !== 16'd4) begin n_fail++; $display("FAIL cw_pos: got %0d want 4", bus.pos); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL cw_pend: got %0d want 0", bus.pend); end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = n_pulse;
        bus.ENC_A = ~bus.ENC_A;
        tick(3);
        bus.ENC_A = ~bus.ENC_A;
        tick(20);
        n_chk++; if (bus.pos !== 16'd4) begin n_fail++; $display("FAIL glitch_pos: got %0d want 4", bus.pos); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL glitch_pend: got %0d want 0", bus.pend); end
        n_chk++; if (n_pulse != p0) begin n_fail++; $display("FAIL glitch_step: got %0d pulses want 0", n_pulse - p0); end
    endtask

    task automatic test_ccw_reverse();
        int kd, ks, p0;
        p0 = n_pulse; kd = -1; ks = -1;
        enc_move(-1);
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (kd < 0 && bus.dir === 1'b0) kd = i;
            if (ks < 0 && bus.step === 1'b1) ks = i;
        end
        n_chk++; if (kd != 9) begin n_fail++; $display("FAIL ccw_dir_fall: got %0d want 9", kd); end
        n_chk++; if (ks - kd != 2) begin n_fail++; $display("FAIL ccw_setup: got %0d want 2", ks - kd); end
        enc_move(-1); tick(20);
        enc_move(-1); tick(20);
        n_chk++; if (n_pulse - p0 != 3) begin n_fail++; $display("FAIL ccw_pulses: got %0d want 3", n_pulse - p0); end
        n_chk++; if (bus.pos !== 16'd1) begin n_fail++; $display("FAIL ccw_pos: got %0d want 1", bus.pos); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL ccw_pend: got %0d want 0", bus.pend); end
    endtask

    task automatic test_saturate();
        int p0, b0;
        bus.EN = 1'b0;
        do_reset();
        // encoder sits at 11: both channels settle together and must not flag err
        tick(20);
        n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ref_err: got %b want 0", bus.err); end
        n_chk++; if (bus.pos !== 16'd0) begin n_fail++; $display("FAIL ref_pos: got %0d want 0", bus.pos); end
        p0 = n_pulse;
        for (int i = 0; i < 7; i++) begin enc_move(1); tick(12); end
        n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_early: got %b want 0", bus.ovf); end
        n_chk++; if (bus.pend !== 4'd7) begin n_fail++; $display("FAIL sat_pend7: got %0d want 7", bus.pend); end
        for (int i = 0; i < 2; i++) begin enc_move(1); tick(12); end
        n_chk++; if (bus.pend !== 4'd7) begin n_fail++; $display("FAIL sat_pend: got %0d want 7", bus.pend); end
        n_chk++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", bus.ovf); end
        n_chk++; if (bus.pos !== 16'd9) begin n_fail++; $display("FAIL sat_pos: got %0d want 9", bus.pos); end
        n_chk++; if (n_pulse != p0) begin n_fail++; $display("FAIL sat_en0: got %0d pulses want 0", n_pulse - p0); end
        b0 = n_badw;
        bus.EN = 1'b1;
        tick(100);
        n_chk++; if (n_pulse - p0 != 7) begin n_fail++; $display("FAIL sat_drain: got %0d pulses want 7", n_pulse - p0); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL sat_pend_end: got %0d want 0", bus.pend); end
        n_chk++; if (n_badw != b0) begin n_fail++; $display("FAIL sat_width: got %0d bad want 0", n_badw - b0); end
    endtask

    task automatic test_illegal();
        int p0;
        p0 = n_pulse;
        enc_move(2);
        tick(20);
        n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", bus.err); end
        n_chk++; if (bus.pos !== 16'd9) begin n_fail++; $display("FAIL ill_pos: got %0d want 9", bus.pos); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL ill_pend: got %0d want 0", bus.pend); end
        n_chk++; if (n_pulse != p0) begin n_fail++; $display("FAIL ill_step: got %0d pulses want 0", n_pulse - p0); end
    endtask

    task automatic test_reset_mid_pulse();
        int k;
        bus.EN = 1'b1;
        enc_move(1); tick(20);
        enc_move(1); tick(20);
        enc_move(1);  // encoder now back at 00
        wait_rise(k);
        n_chk++; if (k != 9) begin n_fail++; $display("FAIL mid_lat: got %0d want 9", k); end
        RSTN = 1'b0;
        @(negedge CLK);
        n_chk++; if (bus.step !== 1'b0) begin n_fail++; $display("FAIL mid_step: got %b want 0", bus.step); end
        n_chk++; if (bus.pos !== 16'd0) begin n_fail++; $display("FAIL mid_pos: got %0d want 0", bus.pos); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL mid_pend: got %0d want 0", bus.pend); end
        n_chk++; if (bus.ovf !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got ovf=%b err=%b want 0 0", bus.ovf, bus.err); end
        bus.EN = 1'b0;
        tick(2);
        RSTN = 1'b1;
        tick(5);
        n_chk++; if (bus.step !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume: got %b want 0", bus.step); end
        enc_move(1); tick(20);
        n_chk++; if (bus.pos !== 16'd0) begin n_fail++; $display("FAIL mid_ref_pos: got %0d want 0", bus.pos); end
        n_chk++; if (bus.pend !== 4'd0) begin n_fail++; $display("FAIL mid_ref_pend: got %0d want 0", bus.pend); end
        enc_move(1); tick(20);
        n_chk++; if (bus.pos !== 16'd1) begin n_fail++; $display("FAIL mid_next_pos: got %0d want 1", bus.pos); end
        enc_move(-1); tick(20);
        enc_move(-1); tick(20);
        n_chk++; if (bus.pos !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pos: got %h want ffff", bus.pos); end
        n_chk++; if (bus.pend !== 4'hF) begin n_fail++; $display("FAIL neg_pend: got %h want f", bus.pend); end
    endtask

    initial begin
        test_reset();
        test_cw_steps();
        test_glitch();
        test_ccw_reverse();
        test_saturate();
        test_illegal();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/enc_step_gen.md
ENC_STEP_GEN -- requirements
Module: enc_step_gen

Interface
REQ-001 Parameter FILT_LEN, 4, consecutive stable cycles required before a synchronised encoder input is accepted.
REQ-002 Parameter STEP_HI, 50, STEP high time in CLK cycles.
REQ-003 Parameter STEP_LO, 50, STEP low time in CLK cycles after each pulse.
REQ-004 Parameter DIR_SETUP, 20, cycles DIR shall be stable before a STEP rising edge following a direction change.
REQ-005 Parameter PEND_W, 8, width of the signed pending-step accumulator.
REQ-006 Port CLK  in  1  the single clock; all logic rising-edge.
REQ-007 Port RSTN  in  1  reset, synchronous, active-low.
REQ-008 Port ENC_A  in  1  asynchronous quadrature channel A.
REQ-009 Port ENC_B  in  1  asynchronous quadrature channel B.
REQ-010 Port EN  in  1  step output enable.
REQ-011 Port step  out  1  step pulse to the stepper driver.
REQ-012 Port dir  out  1  direction to the stepper driver; 1 = CW.
REQ-013 Port pos  out  16  signed encoder position.
REQ-014 Port pend  out  PEND_W  signed steps not yet issued.
REQ-015 Port ovf  out  1  sticky: pending accumulator saturated.
REQ-016 Port err  out  1  sticky: illegal quadrature transition.

Function
REQ-017 ENC_A and ENC_B shall each pass a 2-flop synchroniser, then a glitch filter whose output updates only after the synchronised input differs from it for FILT_LEN consecutive cycles.
REQ-018 Decoding on filtered {A,B}: 00->01->11->10->00 = +1 (CW); reverse order = -1; both bits changing in one cycle = no count, err set.
REQ-019 pos shall add the decoded +1/-1, wrapping in 16-bit two's complement (32767+1 = -32768).
REQ-020 pend shall add the decoded +1/-1 and subtract sign(pend) when a step is issued; both in the same cycle apply as the net sum.
REQ-021 pend shall saturate at +/-(2^(PEND_W-1)-1); a count that would exceed it is dropped from pend only (pos still counts) and sets ovf.
REQ-022 Step FSM states IDLE, SETUP, HIGH, LOW.
REQ-023 IDLE: if EN=1 and pend!=0, target = (pend>0); if target!=dir, load dir=target and go SETUP, else go HIGH.
REQ-024 SETUP: hold DIR_SETUP cycles, then HIGH.
REQ-025 HIGH: step=1 for STEP_HI cycles; pend consumed in the entry cycle; then LOW.
REQ-026 LOW: step=0 for STEP_LO cycles, then IDLE.
REQ-027 dir shall change only on the IDLE->SETUP transition.
REQ-028 EN deasserted in SETUP returns to IDLE without a pulse; in HIGH/LOW the pulse completes normally; pend keeps accumulating while EN=0.
REQ-029 Latency with FSM in IDLE and dir unchanged: ENC edge to step rising = FILT_LEN+5 cycles exactly; +DIR_SETUP when dir changes.

Reset
REQ-030 While RSTN=0 at a CLK edge: step=0, dir=0, pos=0, pend=0, ovf=0, err=0, FSM=IDLE, filter counters cleared.
REQ-031 After reset, the first filtered value of {A,B} shall be loaded as reference without decoding (no count, no err).
REQ-032 Reset mid-pulse shall drop step to 0 on the same edge; no truncated pulse is completed.

Structure
REQ-033 Package enc_step_pkg shall hold the FSM state enum and the quadrature Gray-sequence constants.
REQ-034 Sub-module enc_glitch_filter (one instance per channel, includes synchroniser) shall implement REQ-017.

Verification (FILT_LEN=4, STEP_HI=3, STEP_LO=3, DIR_SETUP=2, PEND_W=4 unless stated)
REQ-035 Four CW edges spaced 20 cycles, EN=1 -> four 3-cycle step pulses, dir=1, pos=4, pend ends 0, first step rising 9 cycles after the first edge (after the initial reversal from dir=0, 11).
REQ-036 ENC_A toggled for 3 cycles then restored -> pos, pend, step unchanged.
REQ-037 After REQ-035, three CCW edges -> dir falls in IDLE, step rises exactly 2 cycles later, three pulses, pos=1.
REQ-038 EN=0, nine CW edges -> pend=7, ovf=1, pos=9; then EN=1 -> exactly seven pulses, pend=0.
REQ-039 ENC_A and ENC_B changed in the same cycle -> err=1, pos and pend unchanged.
REQ-040 RSTN=0 during HIGH -> step=0 on that edge, pos=pend=0, next valid edge produces no count (REQ-031).
